// File: rtl/sram_resp_pkg.sv
// Shared constants for the SRAM responder: MMIO window decode, register offsets, byte-lane geometry.
package sram_resp_pkg;

    localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;
    localparam logic [15:0] TIMER_OFS   = 16'h0000;
    localparam logic [15:0] SCRATCH_OFS = 16'h0004;
    localparam logic [15:0] WRCNT_OFS   = 16'h0008;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    typedef enum logic {
        RSEL_RAM,
        RSEL_MMIO
    } rsel_e;

    function automatic logic [WORD_W-1:0] lane_merge(input logic [WORD_W-1:0] cur,
                                                     input logic [WORD_W-1:0] wdata,
                                                     input logic [LANES-1:0]  wen);
        lane_merge = cur;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wen[i]) lane_merge[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
        end
    endfunction

endpackage

// File: rtl/sram_responder_dp_bram_be.sv
// Two-port RAM: port A read-only, port B byte-write + read, both read-first with registered outputs.
module dp_bram_be
  import sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter              INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_en_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  output logic [WORD_W-1:0] a_rdata_o,
  input  logic              b_en_i,
  input  logic [LANES-1:0]  b_wen_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [WORD_W-1:0] b_wdata_i,
  output logic [WORD_W-1:0] b_rdata_o
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] a_rdata_q;
  logic [WORD_W-1:0] b_rdata_q;

  // Array kept out of the reset domain so reset never disturbs contents.
  always_ff @(posedge clk_i) begin
    if (b_en_i) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (b_wen_i[i]) mem[b_addr_i][i*LANE_W +: LANE_W] <= b_wdata_i[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= mem[a_addr_i];
      if (b_en_i) b_rdata_q <= mem[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Zero-wait memory responder for the core's inst/data SRAM ports: RAM plus a small MMIO register window.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [15:0] MMIO_HI   = MMIO_HI_DEF,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata
);

    logic        data_mmio, mmio_wr, ram_en, ram_wr;
    logic [15:0] mmio_ofs;
    logic [31:0] ram_b_rdata;
    logic [31:0] timer_q, timer_d, scratch_q, scratch_d, wrcnt_q, wrcnt_d;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;
    rsel_e       rsel_q, rsel_d;
    logic        unused_bits;

    assign data_mmio = (data_sram_addr[31:16] == MMIO_HI);
    assign mmio_ofs  = {data_sram_addr[15:2], 2'b00};
    assign ram_en    = data_sram_en && !data_mmio;
    assign ram_wr    = ram_en && (data_sram_wen != '0);
    assign mmio_wr   = data_sram_en && data_mmio && (data_sram_wen != '0);

    assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[31:ADDR_W+2],
                           inst_sram_addr[1:0], data_sram_addr[1:0]};

    dp_bram_be #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i     (clk),
        .rst_ni    (rst),
        .a_en_i    (inst_sram_en),
        .a_addr_i  (inst_sram_addr[ADDR_W+1:2]),
        .a_rdata_o (inst_sram_rdata),
        .b_en_i    (ram_en),
        .b_wen_i   (data_sram_wen),
        .b_addr_i  (data_sram_addr[ADDR_W+1:2]),
        .b_wdata_i (data_sram_wdata),
        .b_rdata_o (ram_b_rdata)
    );

    // Reads sample current register values, so MMIO stays read-first like the RAM.
    always_comb begin
        timer_d      = timer_q + 32'd1;
        scratch_d    = scratch_q;
        wrcnt_d      = wrcnt_q;
        mmio_rdata_d = mmio_rdata_q;
        rsel_d       = rsel_q;
        if (ram_wr) wrcnt_d = wrcnt_q + 32'd1;
        if (data_sram_en) rsel_d = data_mmio ? RSEL_MMIO : RSEL_RAM;
        if (data_sram_en && data_mmio) begin
            case (mmio_ofs)
                TIMER_OFS:   mmio_rdata_d = timer_q;
                SCRATCH_OFS: mmio_rdata_d = scratch_q;
                WRCNT_OFS:   mmio_rdata_d = wrcnt_q;
                default:     mmio_rdata_d = '0;
            endcase
        end
        if (mmio_wr) begin
            case (mmio_ofs)
                TIMER_OFS:   timer_d   = lane_merge(timer_q, data_sram_wdata, data_sram_wen);
                SCRATCH_OFS: scratch_d = lane_merge(scratch_q, data_sram_wdata, data_sram_wen);
                WRCNT_OFS:   wrcnt_d   = '0;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q      <= '0;
            scratch_q    <= '0;
            wrcnt_q      <= '0;
            mmio_rdata_q <= '0;
            rsel_q       <= RSEL_RAM;
        end else begin
            timer_q      <= timer_d;
            scratch_q    <= scratch_d;
            wrcnt_q      <= wrcnt_d;
            mmio_rdata_q <= mmio_rdata_d;
            rsel_q       <= rsel_d;
        end
    end

    assign data_sram_rdata = (rsel_q == RSEL_MMIO) ? mmio_rdata_q : ram_b_rdata;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: reset, byte writes, collisions, hold, MMIO registers, aliasing.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    sram_responder #(
        .ADDR_W  (14),
        .MMIO_HI (16'hBFAF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_sram_en    = 1'b0;
        inst_sram_addr  = '0;
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
    endtask

    task automatic dwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        data_sram_en = 1'b1; data_sram_addr = a; data_sram_wdata = d; data_sram_wen = w;
    endtask

    task automatic drd(input logic [31:0] a);
        data_sram_en = 1'b1; data_sram_addr = a; data_sram_wdata = '0; data_sram_wen = '0;
    endtask

    task automatic ird(input logic [31:0] a);
        inst_sram_en = 1'b1; inst_sram_addr = a;
    endtask

    initial begin
        inst_sram_wen   = 4'hF;
        inst_sram_wdata = 32'hDEAD_DEAD;
        idle();
        rst = 1'b0;

        // Reset held with read requests pending
        ird(32'h100); drd(32'h200);
        tick(); tick(); tick();
        chk("rst_inst", inst_sram_rdata, 32'h0);
        chk("rst_data", data_sram_rdata, 32'h0);

        // Release and read TIMER twice
        rst = 1'b1;
        idle(); drd(32'hBFAF_0000);
        tick(); chk("timer_first", data_sram_rdata, 32'h0);
        tick(); chk("timer_second", data_sram_rdata, 32'h1);

        // Byte-lane write
        idle(); dwr(32'h100, 32'hAABB_CCDD, 4'b1111); tick();
        dwr(32'h100, 32'h0000_1100, 4'b0010); tick();
        chk("wr_readfirst", data_sram_rdata, 32'hAABB_CCDD);
        drd(32'h100); tick();
        chk("byte_write", data_sram_rdata, 32'hAABB_11DD);

        // Collision: inst read vs data write same word
        ird(32'h100); dwr(32'h100, 32'h1234_5678, 4'b1111); tick();
        chk("coll_inst_old", inst_sram_rdata, 32'hAABB_11DD);
        chk("coll_data_old", data_sram_rdata, 32'hAABB_11DD);
        idle(); ird(32'h100); tick();
        chk("coll_inst_new", inst_sram_rdata, 32'h1234_5678);

        // Latency and hold
        idle(); dwr(32'h200, 32'hCAFE_F00D, 4'b1111); tick();
        drd(32'h200); tick();
        chk("lat_read", data_sram_rdata, 32'hCAFE_F00D);
        idle(); dwr(32'h200, 32'h1111_1111, 4'b0000); data_sram_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold", data_sram_rdata, 32'hCAFE_F00D);
        end
        ird(32'h200); drd(32'h200); tick();
        chk("dual_inst", inst_sram_rdata, 32'hCAFE_F00D);
        chk("dual_data", data_sram_rdata, 32'hCAFE_F00D);

        // TIMER load and wrap
        idle(); dwr(32'hBFAF_0000, 32'hFFFF_FFFE, 4'b1111); tick();
        drd(32'hBFAF_0000); tick(); chk("timer_fe", data_sram_rdata, 32'hFFFF_FFFE);
        tick(); chk("timer_ff", data_sram_rdata, 32'hFFFF_FFFF);
        tick(); chk("timer_wrap", data_sram_rdata, 32'h0);

        // SCRATCH lane writes
        dwr(32'hBFAF_0004, 32'h5A00_0000, 4'b1000); tick();
        drd(32'hBFAF_0004); tick(); chk("scratch_hi", data_sram_rdata, 32'h5A00_0000);
        dwr(32'hBFAF_0004, 32'hFFFF_FFC3, 4'b0001); tick();
        drd(32'hBFAF_0004); tick(); chk("scratch_lo", data_sram_rdata, 32'h5A00_00C3);
        drd(32'hBFAF_000C); tick(); chk("unmapped", data_sram_rdata, 32'h0);

        // WR_CNT: clear, 5 RAM writes, 1 MMIO non-WR_CNT write
        dwr(32'hBFAF_0008, 32'h0, 4'b0001); tick();
        for (int i = 0; i < 5; i++) begin
            dwr(32'h300 + 32'(4 * i), 32'(i), 4'b0001); tick();
        end
        dwr(32'hBFAF_0004, 32'h0, 4'b0010); tick();
        drd(32'hBFAF_0008); tick(); chk("wrcnt_5", data_sram_rdata, 32'd5);
        dwr(32'hBFAF_0008, 32'hFFFF_FFFF, 4'b0100); tick();
        drd(32'hBFAF_0008); tick(); chk("wrcnt_clr", data_sram_rdata, 32'h0);

        // Alias: 0x10000 maps to word 0; addr[1:0] ignored
        dwr(32'h0001_0000, 32'h0BAD_BEEF, 4'b1111); tick();
        idle(); ird(32'h0); drd(32'h0001_0003); tick();
        chk("alias_inst", inst_sram_rdata, 32'h0BAD_BEEF);
        chk("alias_data", data_sram_rdata, 32'h0BAD_BEEF);

        // Asynchronous reset mid-cycle
        idle(); ird(32'h0); drd(32'h0);
        #2 rst = 1'b0;
        #1;
        chk("async_inst", inst_sram_rdata, 32'h0);
        chk("async_data", data_sram_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
